intersection_phase_scheduler: RTL
=================================

INTERSECTION_PHASE_SCHEDULER -- requirements
Module: intersection_phase_scheduler

Interface
REQ-001 SHALL have parameter T_GREEN_MIN, default 3, minimum green cycles before gap-out.
REQ-002 SHALL have parameter T_GREEN_MAX, default 8, maximum green cycles while contested.
REQ-003 SHALL have parameter T_YELLOW, default 2, yellow duration in cycles.
REQ-004 SHALL have parameter T_ALLRED, default 1, minimum all-red clearance in cycles.
REQ-005 SHALL have parameter CNT_W, default 8, phase counter width.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port req  input  4  level vehicle-sensor request per approach 0..3.
REQ-009 SHALL have port grant  output  4  one-hot active approach during GREEN/YELLOW, 0 in ALL_RED.
REQ-010 SHALL have port lights  output  8  2 bits per approach, approach i at [2i+1:2i]; 00 red, 01 yellow, 10 green.
REQ-011 SHALL have port phase  output  2  state code: 00 ALL_RED, 01 GREEN, 10 YELLOW.

Function
REQ-012 SHALL implement three states ALL_RED, GREEN, YELLOW; all outputs registered, consistent with state register in the same cycle.
REQ-013 SHALL clear the phase counter on state entry and increment it each cycle in state, saturating at 2^CNT_W-1.
REQ-014 ALL_RED SHALL exit to GREEN at the edge where cnt >= T_ALLRED-1 and req != 0; with req == 0 it SHALL remain ALL_RED (idle).
REQ-015 On ALL_RED exit, winner SHALL be first set req bit searching from (last+1) mod 4 upward with wrap; last := winner.
REQ-016 GREEN SHALL drive winner lights 10, others 00; grant = one-hot winner.
REQ-017 Define other = req & ~grant; GREEN SHALL go to YELLOW when other != 0 and either (own req low and cnt >= T_GREEN_MIN-1: gap-out) or (cnt >= T_GREEN_MAX-1: max-out).
REQ-018 With other == 0, GREEN SHALL hold indefinitely (rest on green) regardless of own req.
REQ-019 YELLOW SHALL drive winner lights 01 and exit to ALL_RED at cnt == T_YELLOW-1; req ignored.
REQ-020 At no time SHALL more than one approach be non-red.
REQ-021 Decisions SHALL use req sampled at the transition edge; req changes in the same cycle as a timeout are honoured.

Reset
REQ-022 On reset: state ALL_RED, cnt 0, last 3 (first search starts at approach 0), grant 0000, lights 0x00, phase 00.
REQ-023 Reset asserted in any state, including mid-GREEN/YELLOW, SHALL produce all-red outputs in the next cycle, no yellow.

Structure
REQ-024 Shared package/include traffic_pkg SHALL hold light encodings (RED 00, YELLOW 01, GREEN 10) and phase state codes; codes are shared with TrafficLightController.
REQ-025 Phase counter with saturation and clear-on-entry SHALL be sub-module phase_timer (clk, reset, clear, cnt); arbiter and FSM stay in the top.
REQ-026 Parameter guards: all T_* >= 1, T_GREEN_MIN <= T_GREEN_MAX, T_GREEN_MAX < 2^CNT_W.

Verification (defaults)
REQ-027 Reset release with req=0001 held -> cycle 1 grant 0001, lights 0x02, held indefinitely.
REQ-028 req=0011 held -> approach 0 green 8 cycles, yellow 2, all-red 1, then approach 1 green 8; alternates.
REQ-029 Approach 0 green, req 0001->0100 at green cycle 1 -> yellow after exactly 3 green cycles, then approach 2.
REQ-030 req=1111 held -> grant sequence 0001,0010,0100,1000,0001; never two non-red approaches.
REQ-031 Reset pulsed at yellow cycle 0 -> next cycle lights 0x00, grant 0000; with req=1111, first grant afterwards is 0001.
REQ-032 req=0000 after reset -> stays ALL_RED, lights 0x00; req=1000 asserted at cycle 5 -> approach 3 green from cycle 6.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared light encodings and phase codes for intersection signal control.
// The codes are common to every traffic controller block that imports this package.
package traffic_pkg;

  localparam int unsigned NumApproaches = 4;

  typedef enum logic [1:0] {
    LightRed    = 2'b00,
    LightYellow = 2'b01,
    LightGreen  = 2'b10
  } light_e;

  typedef enum logic [1:0] {
    PhAllRed = 2'b00,
    PhGreen  = 2'b01,
    PhYellow = 2'b10
  } phase_e;

  // Round-robin pick: first set request strictly after 'last', wrapping.
  // The result is 'last' itself when req is empty or only 'last' is set.
  function automatic logic [1:0] pick_winner(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    win = last;
    // Walk from furthest to nearest so the nearest hit is the one kept.
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: cleared on state entry, otherwise counts up and saturates.
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Four-approach intersection scheduler: round-robin arbiter plus ALL_RED/GREEN/YELLOW FSM.
// Gap-out after a minimum green, max-out when contested, rest on green when uncontested.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned T_GREEN_MIN = 3,
  parameter int unsigned T_GREEN_MAX = 8,
  parameter int unsigned T_YELLOW    = 2,
  parameter int unsigned T_ALLRED    = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [7:0] lights,
  output logic [1:0] phase
);

  if (T_GREEN_MIN < 1 || T_GREEN_MAX < 1 || T_YELLOW < 1 || T_ALLRED < 1) begin : gen_bad_t
    $error("intersection_phase_scheduler: all T_* parameters must be >= 1");
  end
  if (T_GREEN_MIN > T_GREEN_MAX) begin : gen_bad_green
    $error("intersection_phase_scheduler: T_GREEN_MIN must not exceed T_GREEN_MAX");
  end
  if (CNT_W < 1 || CNT_W > 31 || (T_GREEN_MAX >> CNT_W) != 0) begin : gen_bad_cnt
    $error("intersection_phase_scheduler: T_GREEN_MAX must fit below 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] AllRedEnd   = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] GreenMinEnd = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GreenMaxEnd = CNT_W'(T_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YellowEnd   = CNT_W'(T_YELLOW - 1);

  phase_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       grant_q, grant_d;
  logic [7:0]       lights_q, lights_d;
  logic [CNT_W-1:0] cnt;
  logic             clear;
  logic             own_req;
  logic [3:0]       other;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .cnt   (cnt)
  );

  assign own_req = |(req & grant_q);
  assign other   = req & ~grant_q;
  assign clear   = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      PhAllRed: begin
        if (cnt >= AllRedEnd && req != 4'b0000) begin
          state_d = PhGreen;
          last_d  = pick_winner(req, last_q);
        end
      end
      PhGreen: begin
        if (other != 4'b0000 &&
            ((!own_req && cnt >= GreenMinEnd) || cnt >= GreenMaxEnd)) begin
          state_d = PhYellow;
        end
      end
      PhYellow: begin
        if (cnt >= YellowEnd) state_d = PhAllRed;
      end
      default: state_d = PhAllRed;
    endcase
  end

  // Outputs are decoded from the next state so they land with the state register.
  always_comb begin
    grant_d  = 4'b0000;
    lights_d = 8'h00;
    if (state_d != PhAllRed) begin
      grant_d = 4'b0001 << last_d;
    end
    for (int i = 0; i < NumApproaches; i++) begin
      if (grant_d[i]) begin
        lights_d[2*i +: 2] = (state_d == PhGreen) ? LightGreen : LightYellow;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PhAllRed;
      last_q   <= 2'd3;
      grant_q  <= 4'b0000;
      lights_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      lights_q <= lights_d;
    end
  end

  assign grant  = grant_q;
  assign lights = lights_q;
  assign phase  = state_q;

endmodule
